// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution image/kernel loader.
package conv_pkg;

  localparam int unsigned KERN_SZ = 3;
  localparam int unsigned IMG_W   = 4;
  localparam int unsigned IMG_D   = 6;

  localparam int unsigned KW = KERN_SZ * KERN_SZ * IMG_D;
  localparam int unsigned IW = IMG_W * IMG_W * IMG_D;
  localparam int unsigned TW = KW + IW;

  // One word counter serves both phases, so size it for the longer one.
  localparam int unsigned CNT_W = $clog2((IW > KW) ? IW : KW);

  typedef enum logic [2:0] {
    StIdle,
    StKrnl,
    StImg,
    StDone,
    StErr
  } state_e;

  localparam logic KRNL_BANK1 = 1'b0;
  localparam logic KRNL_BANK2 = 1'b1;

endpackage

// File: rtl/conv_tile_demux.sv
// Registered one-hot fan-out of a single kernel/image write onto the per-tile
// memory write ports, plus the per-tile kernel-ready pulse.
module conv_tile_demux
  import conv_pkg::*;
#(
  parameter int unsigned N_TILE   = 480,
  parameter int unsigned TILE_W   = 9,
  parameter int unsigned A_W      = 14,
  parameter int unsigned M_W      = 18,
  parameter int unsigned URAM_D_W = 72,
  parameter int unsigned URAM_A_W = 23
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                wr_img,
  input  logic                wr_bank,
  input  logic [TILE_W-1:0]   wr_tile,
  input  logic [CNT_W-1:0]    wr_addr,
  input  logic [URAM_D_W-1:0] wr_data,
  input  logic                ld_en,
  input  logic [TILE_W-1:0]   ld_tile,
  output logic [URAM_A_W-1:0] uram1_wr_addr     [N_TILE],
  output logic [URAM_D_W-1:0] uram1_wr_data     [N_TILE],
  output logic                uram1_wr_en       [N_TILE],
  output logic [A_W-1:0]      krnl_bram1_wraddr [N_TILE],
  output logic [M_W-1:0]      krnl_bram1_wrdata [N_TILE],
  output logic                krnl_bram1_wren   [N_TILE],
  output logic [A_W-1:0]      krnl_bram2_wraddr [N_TILE],
  output logic [M_W-1:0]      krnl_bram2_wrdata [N_TILE],
  output logic                krnl_bram2_wren   [N_TILE],
  output logic                ld_new_kernel     [N_TILE]
);

  for (genvar t = 0; t < N_TILE; t++) begin : g_tile
    logic sel, sel_k1, sel_k2, sel_img;

    assign sel     = wr_en && (wr_tile == TILE_W'(t));
    assign sel_k1  = sel && !wr_img && (wr_bank == KRNL_BANK1);
    assign sel_k2  = sel && !wr_img && (wr_bank == KRNL_BANK2);
    assign sel_img = sel && wr_img;

    // Address/data only move on a write to this tile; the enable qualifies them.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        uram1_wr_addr[t]     <= '0;
        uram1_wr_data[t]     <= '0;
        uram1_wr_en[t]       <= 1'b0;
        krnl_bram1_wraddr[t] <= '0;
        krnl_bram1_wrdata[t] <= '0;
        krnl_bram1_wren[t]   <= 1'b0;
        krnl_bram2_wraddr[t] <= '0;
        krnl_bram2_wrdata[t] <= '0;
        krnl_bram2_wren[t]   <= 1'b0;
        ld_new_kernel[t]     <= 1'b0;
      end else begin
        uram1_wr_en[t]     <= sel_img;
        krnl_bram1_wren[t] <= sel_k1;
        krnl_bram2_wren[t] <= sel_k2;
        ld_new_kernel[t]   <= ld_en && (ld_tile == TILE_W'(t));
        if (sel_img) begin
          uram1_wr_addr[t] <= URAM_A_W'(wr_addr);
          uram1_wr_data[t] <= wr_data;
        end
        if (sel_k1) begin
          krnl_bram1_wraddr[t] <= A_W'(wr_addr);
          krnl_bram1_wrdata[t] <= wr_data[M_W-1:0];
        end
        if (sel_k2) begin
          krnl_bram2_wraddr[t] <= A_W'(wr_addr);
          krnl_bram2_wrdata[t] <= wr_data[M_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/conv_img_loader.sv
// Stream de-serialiser feeding kernel BRAMs and image URAMs of N_TILE conv tiles
// in order, with framing check on s_last.
module conv_img_loader
  import conv_pkg::*;
#(
  parameter int unsigned A_W      = 14,
  parameter int unsigned M_W      = 18,
  parameter int unsigned URAM_D_W = 72,
  parameter int unsigned URAM_A_W = 23,
  parameter int unsigned N_TILE   = 480
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                krnl_bank,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [URAM_D_W-1:0] s_data,
  input  logic                s_last,
  output logic [URAM_A_W-1:0] uram1_wr_addr     [N_TILE],
  output logic [URAM_D_W-1:0] uram1_wr_data     [N_TILE],
  output logic                uram1_wr_en       [N_TILE],
  output logic [A_W-1:0]      krnl_bram1_wraddr [N_TILE],
  output logic [M_W-1:0]      krnl_bram1_wrdata [N_TILE],
  output logic                krnl_bram1_wren   [N_TILE],
  output logic [A_W-1:0]      krnl_bram2_wraddr [N_TILE],
  output logic [M_W-1:0]      krnl_bram2_wrdata [N_TILE],
  output logic                krnl_bram2_wren   [N_TILE],
  output logic                ld_new_kernel     [N_TILE]
);

  localparam int unsigned TILE_W = (N_TILE > 1) ? $clog2(N_TILE) : 1;

  state_e              state_q, state_d;
  logic [TILE_W-1:0]   tile_q, tile_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                bank_q, bank_d;
  logic                ld_q, ld_d;
  logic [TILE_W-1:0]   ld_tile_q;
  logic                wr_en;
  logic                last_tile;

  assign last_tile = (tile_q == TILE_W'(N_TILE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      tile_q    <= '0;
      cnt_q     <= '0;
      bank_q    <= KRNL_BANK1;
      ld_q      <= 1'b0;
      ld_tile_q <= '0;
    end else begin
      state_q   <= state_d;
      tile_q    <= tile_d;
      cnt_q     <= cnt_d;
      bank_q    <= bank_d;
      ld_q      <= ld_d;
      ld_tile_q <= tile_q;
    end
  end

  always_comb begin
    state_d = state_q;
    tile_d  = tile_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    ld_d    = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          bank_d  = krnl_bank;
          tile_d  = '0;
          cnt_d   = '0;
          state_d = StKrnl;
        end
      end
      StKrnl: begin
        if (s_valid) begin
          wr_en = 1'b1;
          if (s_last) begin
            state_d = StErr;
          end else if (cnt_q == CNT_W'(KW - 1)) begin
            cnt_d   = '0;
            ld_d    = 1'b1;
            state_d = StImg;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StImg: begin
        if (s_valid) begin
          wr_en = 1'b1;
          if (cnt_q == CNT_W'(IW - 1) && last_tile) begin
            state_d = s_last ? StDone : StErr;
          end else if (s_last) begin
            state_d = StErr;
          end else if (cnt_q == CNT_W'(IW - 1)) begin
            tile_d  = tile_q + 1'b1;
            cnt_d   = '0;
            state_d = StKrnl;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign s_ready = (state_q == StKrnl) || (state_q == StImg);
  assign busy    = s_ready;
  assign done    = (state_q == StDone);
  assign err     = (state_q == StErr);

  conv_tile_demux #(
    .N_TILE   (N_TILE),
    .TILE_W   (TILE_W),
    .A_W      (A_W),
    .M_W      (M_W),
    .URAM_D_W (URAM_D_W),
    .URAM_A_W (URAM_A_W)
  ) u_demux (
    .clk               (clk),
    .rst               (rst),
    .wr_en             (wr_en),
    .wr_img            (state_q == StImg),
    .wr_bank           (bank_q),
    .wr_tile           (tile_q),
    .wr_addr           (cnt_q),
    .wr_data           (s_data),
    .ld_en             (ld_q),
    .ld_tile           (ld_tile_q),
    .uram1_wr_addr     (uram1_wr_addr),
    .uram1_wr_data     (uram1_wr_data),
    .uram1_wr_en       (uram1_wr_en),
    .krnl_bram1_wraddr (krnl_bram1_wraddr),
    .krnl_bram1_wrdata (krnl_bram1_wrdata),
    .krnl_bram1_wren   (krnl_bram1_wren),
    .krnl_bram2_wraddr (krnl_bram2_wraddr),
    .krnl_bram2_wrdata (krnl_bram2_wrdata),
    .krnl_bram2_wren   (krnl_bram2_wren),
    .ld_new_kernel     (ld_new_kernel)
  );

endmodule

// File: tb/tb_conv_img_loader.sv
// Directed/randomized bench for conv_img_loader with a two-tile build; expected
// writes are derived from each word's position in the flat transfer.
module tb_conv_img_loader;
  import conv_pkg::*;

  localparam int N        = 2;
  localparam int A_W      = 14;
  localparam int M_W      = 18;
  localparam int URAM_D_W = 72;
  localparam int URAM_A_W = 23;

  logic                clk = 1'b0;
  logic                rst, start, krnl_bank, s_valid, s_last;
  logic                busy, done, err, s_ready;
  logic [URAM_D_W-1:0] s_data;
  logic [URAM_A_W-1:0] uram1_wr_addr     [N];
  logic [URAM_D_W-1:0] uram1_wr_data     [N];
  logic                uram1_wr_en       [N];
  logic [A_W-1:0]      krnl_bram1_wraddr [N];
  logic [M_W-1:0]      krnl_bram1_wrdata [N];
  logic                krnl_bram1_wren   [N];
  logic [A_W-1:0]      krnl_bram2_wraddr [N];
  logic [M_W-1:0]      krnl_bram2_wrdata [N];
  logic                krnl_bram2_wren   [N];
  logic                ld_new_kernel     [N];

  conv_img_loader #(
    .A_W      (A_W),
    .M_W      (M_W),
    .URAM_D_W (URAM_D_W),
    .URAM_A_W (URAM_A_W),
    .N_TILE   (N)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .krnl_bank         (krnl_bank),
    .busy              (busy),
    .done              (done),
    .err               (err),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_data            (s_data),
    .s_last            (s_last),
    .uram1_wr_addr     (uram1_wr_addr),
    .uram1_wr_data     (uram1_wr_data),
    .uram1_wr_en       (uram1_wr_en),
    .krnl_bram1_wraddr (krnl_bram1_wraddr),
    .krnl_bram1_wrdata (krnl_bram1_wrdata),
    .krnl_bram1_wren   (krnl_bram1_wren),
    .krnl_bram2_wraddr (krnl_bram2_wraddr),
    .krnl_bram2_wrdata (krnl_bram2_wrdata),
    .krnl_bram2_wren   (krnl_bram2_wren),
    .ld_new_kernel     (ld_new_kernel)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   j;        // words accepted so far in the current transfer
  logic bank;     // bank captured at start
  logic ld_pend;
  int   ld_tile;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    for (int t = 0; t < N; t++) begin
      chk({tag, "_k1en"}, krnl_bram1_wren[t], 1'b0);
      chk({tag, "_k2en"}, krnl_bram2_wren[t], 1'b0);
      chk({tag, "_uen"}, uram1_wr_en[t], 1'b0);
      chk({tag, "_ld"}, ld_new_kernel[t], 1'b0);
    end
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_ready"}, s_ready, 1'b0);
  endtask

  task automatic start_xfer(input logic b);
    krnl_bank = b;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    krnl_bank = ~b;
    bank      = b;
    j         = 0;
    ld_pend   = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_ready", s_ready, 1'b1);
  endtask

  // vmode: 0 back-to-back, 1 toggle 1-0, 2 random valid.
  task automatic stream(input int last_idx, input int vmode, input int abort_at,
                        input int start_at);
    int          cyc = 0;
    bit          term = 0;
    logic [71:0] d;
    logic        v, l, hs;
    int          tile, r, addr;
    bit          is_k, fin;
    while (!term) begin
      if (cyc > 3000) begin
        n_tests++;
        n_fail++;
        $display("FAIL timeout: observed no completion expected done/err within 3000 cycles");
        return;
      end
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      d = {8'($urandom()), $urandom(), $urandom()};
      l = (j == last_idx);
      s_valid = v;
      s_data  = d;
      s_last  = l;
      start   = (cyc == start_at);
      hs      = v && s_ready;
      @(posedge clk); #1;
      start   = 1'b0;
      s_valid = 1'b0;
      tile = j / TW;
      r    = j % TW;
      is_k = r < KW;
      addr = is_k ? r : r - KW;
      fin  = (j == N * TW - 1);
      for (int t = 0; t < N; t++) begin
        chk("k1_en", krnl_bram1_wren[t], hs && is_k && !bank && tile == t);
        chk("k2_en", krnl_bram2_wren[t], hs && is_k && bank && tile == t);
        chk("u_en", uram1_wr_en[t], hs && !is_k && tile == t);
        chk("ld", ld_new_kernel[t], ld_pend && ld_tile == t);
        if (hs && tile == t) begin
          if (is_k && !bank) begin
            chk("k1_addr", krnl_bram1_wraddr[t], 72'(addr));
            chk("k1_data", krnl_bram1_wrdata[t], 72'(d[M_W-1:0]));
          end else if (is_k) begin
            chk("k2_addr", krnl_bram2_wraddr[t], 72'(addr));
            chk("k2_data", krnl_bram2_wrdata[t], 72'(d[M_W-1:0]));
          end else begin
            chk("u_addr", uram1_wr_addr[t], 72'(addr));
            chk("u_data", uram1_wr_data[t], d);
          end
        end
      end
      ld_pend = hs && is_k && r == KW - 1 && !l;
      ld_tile = tile;
      term    = hs && (fin || l);
      chk("done", done, hs && fin && l);
      chk("err", err, hs && (l != fin));
      chk("busy", busy, !term);
      chk("ready", s_ready, !term);
      if (hs) j++;
      cyc++;
      if (abort_at >= 0 && j == abort_at && !term) begin
        rst = 1'b1;
        #1;
        chk_quiet("abort");
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    chk_quiet("post");
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    krnl_bank = 1'b0;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    s_data    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_quiet("idle");

    // Clean transfer, bank 0, back-to-back.
    start_xfer(1'b0);
    stream(N * TW - 1, 0, -1, -1);

    // Bank 1, valid toggling.
    start_xfer(1'b1);
    stream(N * TW - 1, 1, -1, -1);

    // Early s_last on tile0 image word 5.
    start_xfer(1'b0);
    stream(KW + 5, 0, -1, -1);

    // Final word without s_last.
    start_xfer(1'b1);
    stream(-1, 0, -1, -1);

    // Reset after 100 words, then a full restart with random stalls.
    start_xfer(1'b0);
    stream(N * TW - 1, 0, 100, -1);
    @(posedge clk); #1;
    chk_quiet("after_abort");
    start_xfer(1'b1);
    stream(N * TW - 1, 2, -1, -1);

    // start pulsed mid-transfer must be ignored.
    start_xfer(1'b0);
    stream(N * TW - 1, 2, -1, 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_img_loader.md
Name: conv_img_loader

Overview:
- Upstream feeder for the DSP convolution chip array.
- Accepts one valid/ready word stream and de-serialises it into per-tile kernel BRAM writes and image URAM writes for N_TILE convolution tiles, visiting the tiles in order.
- Pulses each tile's ld_new_kernel once that tile's kernel is complete.
- Reports done or framing error per transfer.

Parameters:
- KERN_SZ, 3, kernel edge length.
- IMG_W, 4, image edge length.
- IMG_D, 6, image depth (channels).
- A_W, 14, kernel BRAM address width.
- M_W, 18, kernel word width.
- URAM_D_W, 72, image word width.
- URAM_A_W, 23, URAM address width.
- N_TILE, 480, number of tiles fed.
- Derived, not overridable:
  - KW = KERN_SZ*KERN_SZ*IMG_D = 54
  - IW = IMG_W*IMG_W*IMG_D = 96
  - TW = KW+IW = 150

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin transfer; sampled only in IDLE.
- krnl_bank  in  1  captured at start; 0 = write krnl_bram1, 1 = write krnl_bram2.
- busy  out  1  high from the cycle after an accepted start until DONE/ERR.
- done  out  1  one-cycle pulse on clean completion.
- err  out  1  one-cycle pulse on framing error.
- s_valid  in  1  stream word valid.
- s_ready  out  1  stream ready.
- s_data  in  URAM_D_W  stream word.
- s_last  in  1  marks the final word of the transfer.
- uram1_wr_addr[N_TILE]  out  URAM_A_W  image write address.
- uram1_wr_data[N_TILE]  out  URAM_D_W  image write data.
- uram1_wr_en[N_TILE]  out  1  image write enable.
- krnl_bram1_wraddr[N_TILE] / krnl_bram2_wraddr[N_TILE]  out  A_W  kernel write address.
- krnl_bram1_wrdata[N_TILE] / krnl_bram2_wrdata[N_TILE]  out  M_W  kernel write data, taken from s_data[M_W-1:0].
- krnl_bram1_wren[N_TILE] / krnl_bram2_wren[N_TILE]  out  1  kernel write enable.
- ld_new_kernel[N_TILE]  out  1  kernel-ready pulse.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters 0. Reset asserted mid-transfer aborts immediately: no further enables, and no done or err.
- FSM states:
  - IDLE: s_ready=0. start=1 captures krnl_bank, clears tile/word counters, moves to KRNL.
  - KRNL: s_ready=1. Each handshake (s_valid & s_ready) writes one kernel word; word counter k runs 0..KW-1. After k=KW-1, move to IMG.
  - IMG: s_ready=1. Each handshake writes one image word; counter i runs 0..IW-1. After i=IW-1:
    - tile != N_TILE-1: tile++, counters clear, back to KRNL.
    - otherwise: DONE.
  - DONE: one cycle; done=1; return to IDLE.
  - ERR: one cycle; err=1; return to IDLE.
- Write timing: every write is registered, one cycle after its handshake.
  - Only the current tile's selected enable is high; all other tiles' enables stay 0.
  - Kernel address = k, zero-extended to A_W.
  - Image address = i, zero-extended to URAM_A_W.
  - Address and data outputs for non-selected tiles hold their last value; the enable is the only qualifier.
- ld_new_kernel[tile]: one-cycle pulse in the cycle after the last kernel write enable, i.e. two cycles after the handshake of word KW-1.
- Framing check:
  - s_last accepted on any word other than the global final word (tile N_TILE-1, i=IW-1): that word is still written, then go to ERR.
  - Global final word accepted with s_last=0: word is written, then go to ERR instead of DONE.
- Stalls: s_valid=0 holds all counters; enables are 0 in stalled cycles. Back-to-back accepts give one word per cycle.
- start while busy: ignored.
- Final handshake to done: done asserts the cycle after the final handshake, coincident with the final write enable.

Decomposition:
- Shared package conv_pkg: localparams KW, IW, TW; state enum {IDLE, KRNL, IMG, DONE, ERR}; the KRNL_BANK1/KRNL_BANK2 encodings.
- One sub-module, conv_tile_demux: registered one-hot fan-out of a single write (tile index, kind, address, data, enable) onto the N_TILE output arrays. The top module holds the FSM and counters only.

Test Plan:
1. Reset, then start with krnl_bank=0 and N_TILE=2; stream 300 words back-to-back with s_last on word 300.
   -> tile0 gets krnl_bram1_wren for addresses 0..53, then uram1_wr_en for addresses 0..95; tile1 likewise.
   -> ld_new_kernel[0] pulses once; done pulses once; krnl_bram2_wren and err are never asserted.
2. Same transfer with krnl_bank=1 and s_valid toggling 1-0.
   -> Only krnl_bram2 is written. No write enable occurs in a cycle following a stalled (non-handshake) cycle. Data of word j lands at its expected address.
3. s_last on word 60 (tile0 image i=5).
   -> That word is written at URAM address 5; err pulses; busy falls; tile1 is never written.
4. Word 300 sent with s_last=0.
   -> Written at tile1 URAM address 95; err=1, done=0.
5. Assert rst after 100 words.
   -> All enables drop immediately; busy=0, no done. A new start afterwards restarts at tile0, kernel address 0.
6. Pulse start while busy.
   -> No effect on counters; exactly one done at the end.
